// File: rtl/dac_reg_spi_arbiter.sv
// Two-requester arbiter for the shared DAC / mode-register SPI bus (mode 0, MSB first).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with register over DAC.
module dac_reg_spi_arbiter #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned DAC_BITS = 16,
   parameter int unsigned REG_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dac_req,
   input  logic [DAC_BITS-1:0] dac_data,
   output logic                dac_done,
   input  logic                reg_req,
   input  logic [REG_BITS-1:0] reg_data,
   output logic                reg_done,
   output logic                busy,
   output logic                spi_sck,
   output logic                spi_mosi,
   output logic                cs1_dac,
   output logic                cs2_reg
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned CNT_W = $clog2(DAC_BITS + 1);
   localparam int unsigned PAD   = DAC_BITS - REG_BITS;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
   typedef enum logic {W_DAC, W_REG} who_t;

   state_t              state_q, state_d;
   who_t                who_q, who_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [CNT_W-1:0]    bits_q, bits_d;
   logic [DAC_BITS-1:0] shreg_q, shreg_d;
   logic                sck_q, sck_d;

   logic                phase_end;
   logic                done_pulse;
   logic                cs_active;
   logic                grant_reg;
   logic [DAC_BITS-1:0] reg_aligned;

   assign phase_end   = (div_q == DIV_LAST);
   assign done_pulse  = (state_q == S_GAP) && phase_end;
   assign cs_active   = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
   assign reg_aligned = DAC_BITS'(reg_data) << PAD;

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer remembers the last requester that completed; reset favours the register side.
   logic last_dac_q;

   always_ff @(posedge clk) begin
      if (rst)             last_dac_q <= 1'b1;
      else if (done_pulse) last_dac_q <= (who_q == W_DAC);
   end

   assign grant_reg = reg_req && (!dac_req || last_dac_q);
`else
   assign grant_reg = reg_req;
`endif

   // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         who_q   <= W_DAC;
         div_q   <= '0;
         bits_q  <= '0;
         shreg_q <= '0;
         sck_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         who_q   <= who_d;
         div_q   <= div_d;
         bits_q  <= bits_d;
         shreg_q <= shreg_d;
         sck_q   <= sck_d;
      end
   end

   // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      who_d   = who_q;
      div_d   = div_q + 1'b1;
      bits_d  = bits_q;
      shreg_d = shreg_q;
      sck_d   = sck_q;

      unique case (state_q)
         S_IDLE: begin
            div_d = '0;
            if (dac_req || reg_req) begin
               state_d = S_SETUP;
               if (grant_reg) begin
                  who_d   = W_REG;
                  shreg_d = reg_aligned;
                  bits_d  = CNT_W'(REG_BITS);
               end else begin
                  who_d   = W_DAC;
                  shreg_d = dac_data;
                  bits_d  = CNT_W'(DAC_BITS);
               end
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               div_d   = '0;
               sck_d   = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (phase_end) begin
               div_d = '0;
               if (sck_q) begin
                  // Falling edge: one bit consumed; the final bit stays on MOSI.
                  sck_d  = 1'b0;
                  bits_d = bits_q - 1'b1;
                  if (bits_q != CNT_W'(1)) shreg_d = shreg_q << 1;
               end else if (bits_q == '0) begin
                  state_d = S_HOLD;
               end else begin
                  sck_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (phase_end) begin
               div_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (phase_end) begin
               div_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            div_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign spi_sck  = sck_q;
   assign spi_mosi = cs_active & shreg_q[DAC_BITS-1];
   assign cs1_dac  = !(cs_active && (who_q == W_DAC));
   assign cs2_reg  = !(cs_active && (who_q == W_REG));
   assign dac_done = done_pulse && (who_q == W_DAC);
   assign reg_done = done_pulse && (who_q == W_REG);

endmodule

// File: tb/tb_dac_reg_spi_arbiter.sv
// Self-checking bench for dac_reg_spi_arbiter: random words, a bus monitor and a cycle-level transaction model.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_dac_reg_spi_arbiter;

   localparam int CLK_DIV  = 4;
   localparam int DAC_BITS = 16;
   localparam int REG_BITS = 8;

   logic                clk;
   logic                rst;
   logic                dac_req;
   logic [DAC_BITS-1:0] dac_data;
   logic                dac_done;
   logic                reg_req;
   logic [REG_BITS-1:0] reg_data;
   logic                reg_done;
   logic                busy;
   logic                spi_sck;
   logic                spi_mosi;
   logic                cs1_dac;
   logic                cs2_reg;

   dac_reg_spi_arbiter #(
      .CLK_DIV (CLK_DIV),
      .DAC_BITS(DAC_BITS),
      .REG_BITS(REG_BITS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dac_req (dac_req),
      .dac_data(dac_data),
      .dac_done(dac_done),
      .reg_req (reg_req),
      .reg_data(reg_data),
      .reg_done(reg_done),
      .busy    (busy),
      .spi_sck (spi_sck),
      .spi_mosi(spi_mosi),
      .cs1_dac (cs1_dac),
      .cs2_reg (cs2_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_now = 0;

   always @(posedge clk) cyc_now++;

   // ---------------- bus monitor: one record per completed transaction ----------------
   typedef struct {
      bit          is_reg;
      bit          sel_reg;
      bit          other_low;
      int          len;
      int          rel_done;
      int          abs_done;
      int          gap;
      int          nb;
      logic [31:0] bits;
   } rec_t;

   rec_t rec_q[$];
   rec_t cur;
   bit   in_txn = 1'b0;
   int   gap_run = 0;
   int   overlap_cnt = 0;
   int   stray_done = 0;
   logic sck_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         in_txn   = 1'b0;
         sck_prev = 1'b0;
         gap_run  = 0;
      end else begin
         if (!cs1_dac && !cs2_reg) overlap_cnt++;
         if (!in_txn && (!cs1_dac || !cs2_reg)) begin
            in_txn      = 1'b1;
            cur         = '{default: 0};
            cur.sel_reg = !cs2_reg;
            cur.gap     = gap_run;
         end
         if (cs1_dac && cs2_reg) gap_run++;
         else                    gap_run = 0;
         if (in_txn) begin
            cur.rel_done++;
            if (cur.sel_reg ? !cs2_reg : !cs1_dac) cur.len++;
            if (cur.sel_reg ? !cs1_dac : !cs2_reg) cur.other_low = 1'b1;
            if (spi_sck && !sck_prev) begin
               cur.bits = {cur.bits[30:0], spi_mosi};
               cur.nb++;
            end
         end
         if (dac_done || reg_done) begin
            if (!in_txn || (dac_done && reg_done)) begin
               stray_done++;
            end else begin
               cur.is_reg   = reg_done;
               cur.abs_done = cyc_now;
               rec_q.push_back(cur);
               in_txn = 1'b0;
            end
         end
         sck_prev = spi_sck;
      end
   end

   // ---------------- behavioural reference model ----------------
   typedef struct {
      bit          is_reg;
      logic [31:0] word;
      int          nb;
      int          cs_len;
      int          dur;
      int          grant_cyc;
      int          prev_end;
   } exp_t;

   exp_t exp_q[$];
   bit   last_dac_m = 1'b1;
   logic [DAC_BITS-1:0] dac_words_q[$];
   logic [REG_BITS-1:0] reg_words_q[$];

   // Winner among pending requests: register always, or alternate on a tie in round-robin mode.
   function automatic bit pick_reg(input bit d, input bit r);
`ifdef ARB_ROUND_ROBIN_EN
      if (d && r) return last_dac_m;
      return r;
`else
      return r;
`endif
   endfunction

   function automatic logic [DAC_BITS-1:0] next_dac();
      if (dac_words_q.size() > 0) return dac_words_q.pop_front();
      return DAC_BITS'($urandom);
   endfunction

   function automatic logic [REG_BITS-1:0] next_reg();
      if (reg_words_q.size() > 0) return reg_words_q.pop_front();
      return REG_BITS'($urandom);
   endfunction

   // Runs n_dac DAC words and n_reg register words (register side starts reg_delay cycles late),
   // each requester holding req until its done, and checks every transaction against the model.
   task automatic serve(input string tag, input int n_dac, input int n_reg,
                        input int reg_delay, input bit scramble);
      int   rem_d, rem_r, start, free_at, prev_end, budget;
      bit   reg_started, active, w;
      exp_t e, cur_e;
      rec_t r;
      rem_d = n_dac;
      rem_r = n_reg;
      reg_started = 1'b0;
      active   = 1'b0;
      prev_end = -1;
      cur_e    = '{default: 0};
      budget   = (n_dac + n_reg) * (CLK_DIV * (2 * DAC_BITS + 3) + 2) + reg_delay + 100;
      @(posedge clk); #1;
      start   = cyc_now;
      free_at = cyc_now + 1;
      if (rem_d > 0) begin
         dac_data = next_dac();
         dac_req  = 1'b1;
      end
      while ((rem_d > 0 || rem_r > 0 || exp_q.size() > 0) && (cyc_now - start) < budget) begin
         while (rec_q.size() > 0) begin
            r = rec_q.pop_front();
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL %s unexpected_done: got reg=%0b, none expected", tag, r.is_reg);
            end else begin
               e = exp_q.pop_front();
               total++;
               if (r.is_reg !== e.is_reg) begin bad++; $display("FAIL %s winner: got reg=%0b want reg=%0b", tag, r.is_reg, e.is_reg); end
               total++;
               if (r.sel_reg !== e.is_reg) begin bad++; $display("FAIL %s cs_select: got reg=%0b want reg=%0b", tag, r.sel_reg, e.is_reg); end
               total++;
               if (r.nb !== e.nb) begin bad++; $display("FAIL %s bit_count: got %0d want %0d", tag, r.nb, e.nb); end
               total++;
               if (r.bits !== e.word) begin bad++; $display("FAIL %s bits: got %h want %h", tag, r.bits, e.word); end
               total++;
               if (r.len !== e.cs_len) begin bad++; $display("FAIL %s cs_low_len: got %0d want %0d", tag, r.len, e.cs_len); end
               total++;
               if (r.rel_done !== e.dur) begin bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, r.rel_done, e.dur); end
               total++;
               if (r.abs_done !== e.grant_cyc + e.dur - 1) begin bad++; $display("FAIL %s done_time: got %0d want %0d", tag, r.abs_done, e.grant_cyc + e.dur - 1); end
               total++;
               if (r.other_low !== 1'b0) begin bad++; $display("FAIL %s other_cs: got low want high", tag); end
               if (e.prev_end >= 0) begin
                  total++;
                  if (r.gap !== e.grant_cyc - e.prev_end) begin bad++; $display("FAIL %s cs_gap: got %0d want %0d", tag, r.gap, e.grant_cyc - e.prev_end); end
               end
            end
            if (r.is_reg && rem_r > 0) begin
               rem_r--;
               if (rem_r > 0) reg_data = next_reg();
               else           reg_req = 1'b0;
            end else if (!r.is_reg && rem_d > 0) begin
               rem_d--;
               if (rem_d > 0) dac_data = next_dac();
               else           dac_req = 1'b0;
            end
         end
         if (!reg_started && rem_r > 0 && (cyc_now - start) >= reg_delay) begin
            reg_started = 1'b1;
            reg_data = next_reg();
            reg_req  = 1'b1;
         end
         // Disturb the granted word while it is being shifted; the latched copy must win.
         if (scramble && active && cyc_now >= cur_e.grant_cyc &&
             cyc_now < cur_e.grant_cyc + cur_e.cs_len - 1) begin
            if (cur_e.is_reg) reg_data = REG_BITS'($urandom);
            else              dac_data = DAC_BITS'($urandom);
         end
         if (cyc_now + 1 >= free_at && (dac_req || reg_req)) begin
            w           = pick_reg(dac_req, reg_req);
            e.is_reg    = w;
            e.nb        = w ? REG_BITS : DAC_BITS;
            e.word      = w ? 32'(reg_data) : 32'(dac_data);
            e.cs_len    = CLK_DIV * (2 * e.nb + 2);
            e.dur       = CLK_DIV * (2 * e.nb + 3);
            e.grant_cyc = cyc_now + 1;
            e.prev_end  = prev_end;
            exp_q.push_back(e);
            cur_e      = e;
            active     = 1'b1;
            free_at    = e.grant_cyc + e.dur + 1;
            prev_end   = e.grant_cyc + e.cs_len;
            last_dac_m = !w;
         end
         @(posedge clk); #1;
      end
      if (rem_d > 0 || rem_r > 0 || exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL %s timeout: dac_left=%0d reg_left=%0d pending=%0d, want all 0", tag, rem_d, rem_r, exp_q.size());
      end
      exp_q.delete();
      dac_req = 1'b0;
      reg_req = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (spi_sck  !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
      total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
      total++; if (cs1_dac  !== 1'b1) begin bad++; $display("FAIL reset_cs1: got %b want 1", cs1_dac); end
      total++; if (cs2_reg  !== 1'b1) begin bad++; $display("FAIL reset_cs2: got %b want 1", cs2_reg); end
      total++; if (busy     !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (dac_done !== 1'b0) begin bad++; $display("FAIL reset_dac_done: got %b want 0", dac_done); end
      total++; if (reg_done !== 1'b0) begin bad++; $display("FAIL reset_reg_done: got %b want 0", reg_done); end
      rst = 1'b0;
      last_dac_m = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_dac_single();
      dac_words_q.push_back(16'hA5C3);
      serve("dac_a5c3", 1, 0, 0, 0);
   endtask

   task automatic test_reg_single();
      reg_words_q.push_back(8'h81);
      serve("reg_81", 0, 1, 0, 0);
   endtask

   task automatic test_random_single();
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(1, 0) == 1) serve("rand_dac", 1, 0, 0, 1);
         else                           serve("rand_reg", 0, 1, 0, 1);
      end
   endtask

   task automatic test_pair_twice();
      serve("pair_1", 1, 1, 0, 0);
      serve("pair_2", 1, 1, 0, 0);
   endtask

   task automatic test_lone_then_pair();
      serve("lone_dac", 1, 0, 0, 0);
      serve("pair_after_dac", 1, 1, 0, 0);
   endtask

   task automatic test_held_both();
      serve("held_both", 2, 2, 0, 1);
   endtask

   task automatic test_back_to_back();
      dac_words_q.push_back(16'h0001);
      dac_words_q.push_back(16'hFFFF);
      serve("b2b_dac", 2, 0, 0, 0);
   endtask

   task automatic test_reg_mid_dac();
      serve("reg_mid_dac", 1, 1, 50, 1);
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 1'b0;
      @(posedge clk); #1;
      dac_data = DAC_BITS'($urandom);
      dac_req  = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk); #1;
         if (!cs1_dac) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rst_mid_start: cs1_dac got high want low within 10 cycles"); end
      // Cycle 38 of CS low lies inside the 5th bit's SCK-high phase.
      repeat (37) @(posedge clk);
      #1;
      total++; if (spi_sck !== 1'b1) begin bad++; $display("FAIL rst_mid_sck_phase: got %b want 1", spi_sck); end
      rst     = 1'b1;
      dac_req = 1'b0;
      @(posedge clk); #1;
      total++; if (cs1_dac  !== 1'b1) begin bad++; $display("FAIL rst_mid_cs1: got %b want 1", cs1_dac); end
      total++; if (spi_sck  !== 1'b0) begin bad++; $display("FAIL rst_mid_sck: got %b want 0", spi_sck); end
      total++; if (busy     !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mid_mosi: got %b want 0", spi_mosi); end
      rst = 1'b0;
      last_dac_m = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      total++; if (rec_q.size() !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d dones want 0", rec_q.size()); end
      rec_q.delete();
      serve("after_rst", 1, 0, 0, 0);
   endtask

   task automatic test_bus_rules();
      total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL both_cs_low: got %0d cycles want 0", overlap_cnt); end
      total++; if (stray_done !== 0) begin bad++; $display("FAIL stray_done: got %0d want 0", stray_done); end
   endtask

   initial begin
      rst      = 1'b1;
      dac_req  = 1'b0;
      reg_req  = 1'b0;
      dac_data = '0;
      reg_data = '0;
      test_reset();
      test_dac_single();
      test_reg_single();
      test_random_single();
      test_pair_twice();
      test_lone_then_pair();
      test_held_both();
      test_back_to_back();
      test_reg_mid_dac();
      test_reset_mid();
      test_bus_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dac_reg_spi_arbiter.md
# dac_reg_spi_arbiter

Shares the single DAC/mode-register SPI bus (shared SCK and MOSI, separate chip selects `cs1_dac` and `cs2_reg`) between two requesters: the DAC setpoint writer and the measurement-mode register writer. It sits between the acquisition sequencer and the board SPI pins. It arbitrates pending requests, serializes the latched word MSB-first in SPI mode 0, and returns a one-cycle `done` pulse per transaction.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period; legal range 2..255.
- `DAC_BITS`, 16: DAC word length.
- `REG_BITS`, 8: mode-register word length.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `dac_req` in 1: DAC write request, held until `dac_done`.
- `dac_data` in DAC_BITS: DAC word, stable while `dac_req` is high.
- `dac_done` out 1: one-cycle pulse, DAC transaction complete.
- `reg_req` in 1: mode-register write request, held until `reg_done`.
- `reg_data` in REG_BITS: register word.
- `reg_done` out 1: one-cycle pulse, register transaction complete.
- `busy` out 1: high from SETUP through GAP.
- `spi_sck` out 1: shared serial clock, idles low.
- `spi_mosi` out 1: shared serial data.
- `cs1_dac` out 1: DAC chip select, active-low.
- `cs2_reg` out 1: register chip select, active-low.

## Operation
- Reset values: `spi_sck`=0, `spi_mosi`=0, `cs1_dac`=1, `cs2_reg`=1, `busy`=0, both `done`=0, RR pointer = "last served DAC".
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: the requests are sampled. If any request is high, the arbiter picks a winner and loads its data, left-aligned, into a DAC_BITS shift register. It loads the bit count (DAC_BITS or REG_BITS) and enters SETUP.
- SETUP (CLK_DIV cycles): the winner's CS is low, SCK is low, and MOSI carries the MSB.
- SHIFT: SCK toggles every CLK_DIV cycles, starting with a rising edge, for N high and N low phases. MOSI advances to the next bit on each falling edge except the last. The slave samples on rising edges.
- HOLD (CLK_DIV cycles): CS stays low and SCK stays low.
- GAP (CLK_DIV cycles): both CSes are high and MOSI is 0. The winner's `done` is pulsed on the last GAP cycle, then the FSM returns to IDLE.
- Arbitration is fixed priority by default, with the register requester winning. See Configuration for the alternative.
- Requests arriving while `busy` is high stay pending and are arbitrated in the next IDLE cycle.
- A requester that keeps `req` high after `done` gets another transaction. The minimum CS-high gap is CLK_DIV+1 cycles.
- Changing `*_data` while the request is granted has no effect, because the word is latched in IDLE.
- At most one CS is low at any time.

## Timing
- Latency from `req` high (sampled in IDLE) to CS low is 1 cycle.
- CS is low for CLK_DIV*(2N+2) cycles.
- `done` fires on cycle CLK_DIV*(2N+3) counted from the first CS-low cycle (1-based).
- With CLK_DIV=4:
  - DAC: CS low 136 cycles, `done` on cycle 140.
  - Register: CS low 72 cycles, `done` on cycle 76.
- SCK period is 2*CLK_DIV cycles. MOSI is stable at least CLK_DIV cycles either side of each rising edge.
- Reset mid-transaction: on the next edge the outputs take their reset values, no `done` is issued, and the partial word is discarded.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. On simultaneous requests, the requester not served last wins.
  - The pointer updates when `done` is issued.
  - After reset, the register requester wins the first tie.
- Undefined: fixed priority, with the register requester always beating the DAC requester.

## Test plan
- DAC only, `dac_data`=0xA5C3, CLK_DIV=4 -> `cs1_dac` low 136 cycles; bits sampled on rising SCK = 1010_0101_1100_0011; `cs2_reg` stays high; single `dac_done` pulse on cycle 140.
- Register only, `reg_data`=0x81 -> `cs2_reg` low 72 cycles; bits 1000_0001; `reg_done` on cycle 76.
- Both requests in the same cycle, twice, fixed priority -> reg, DAC, reg, DAC. With `ARB_ROUND_ROBIN_EN` and both requests held continuously -> reg, DAC, reg, DAC. With `ARB_ROUND_ROBIN_EN` and a lone DAC transfer followed by a simultaneous pair -> reg served first.
- `rst` asserted during the 5th DAC bit -> next cycle `cs1_dac`=1, `spi_sck`=0, `busy`=0, no `dac_done`; a following request completes normally.
- `dac_req` held high for two words (0x0001 then 0xFFFF, data swapped on `dac_done`) -> two transfers with `cs1_dac` high for exactly 5 cycles between them.
- `reg_req` raised mid-DAC transfer -> DAC completes unaltered; `cs2_reg` goes low 1 cycle after IDLE is reached.
